// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (I) and mem-stage (D) ports, one access at a time.
// Latency: request seen in IDLE -> m_en next cycle -> ack MEM_LAT+2 cycles after the request.
// Backpressure: requesters hold req until their ack pulse; stall_f/stall_m stay high while waiting.
module mem_port_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        stall_f,
    output logic        stall_m,
    output logic        busy
);

    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          grant_d;
    logic          last_grant_d;

    logic i_elig;
    logic d_elig;
    logic pick_d;

    // A request whose ack is high this cycle belongs to the transaction just completed.
    assign i_elig = i_req & ~i_ack;
    assign d_elig = d_req & ~d_ack;
    assign pick_d = d_elig & (~i_elig | ~last_grant_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            grant_d      <= 1'b0;
            last_grant_d <= 1'b0;
            m_en         <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
        end else begin
            m_en  <= 1'b0;
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_elig || d_elig) begin
                        grant_d      <= pick_d;
                        last_grant_d <= pick_d;
                        m_addr       <= pick_d ? d_addr : i_addr;
                        m_we         <= pick_d & d_we;
                        m_wdata      <= pick_d ? d_wdata : 32'h0;
                        m_en         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= CW'(1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == CW'(MEM_LAT)) begin
                        // m_we still holds the granted transaction's direction here.
                        if (!m_we) begin
                            if (grant_d) d_rdata <= m_rdata;
                            else         i_rdata <= m_rdata;
                        end
                        if (grant_d) d_ack <= 1'b1;
                        else         i_ack <= 1'b1;
                        state <= ACK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign stall_f = i_req & ~i_ack;
    assign stall_m = d_req & ~d_ack;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: two arbiters (MEM_LAT 1 and 3) with random requesters and a memory model, checked every
// cycle against a transaction-level model (grant cycle -> issue at +1, ack at +MEM_LAT+2).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req   [2];
    logic [31:0] i_addr  [2];
    logic [31:0] i_rdata [2];
    logic        i_ack   [2];
    logic        d_req   [2];
    logic        d_we    [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic [31:0] d_rdata [2];
    logic        d_ack   [2];
    logic        m_en    [2];
    logic        m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rdata [2];
    logic        stall_f [2];
    logic        stall_m [2];
    logic        busy    [2];

    mem_port_arbiter #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_ack(i_ack[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_ack(d_ack[0]),
        .m_en(m_en[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
        .m_rdata(m_rdata[0]), .stall_f(stall_f[0]), .stall_m(stall_m[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_ack(i_ack[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_ack(d_ack[1]),
        .m_en(m_en[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
        .m_rdata(m_rdata[1]), .stall_f(stall_f[1]), .stall_m(stall_m[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // environment: memory contents and history of issued accesses
    logic [31:0] env_mem [2][64];
    bit          h_en    [2][16];
    bit          h_we    [2][16];
    logic [31:0] h_addr  [2][16];
    bit          iack_prev [2];
    bit          dack_prev [2];

    // reference model state
    logic [31:0] mdl_mem [2][64];
    bit          mb [2];
    bit          mg [2];
    bit          mlast [2];
    int          mti [2];
    int          mta [2];
    logic [31:0] e_irdata [2];
    logic [31:0] e_drdata [2];
    logic [31:0] e_maddr  [2];
    logic [31:0] e_mwdata [2];
    logic [31:0] mrd      [2];
    bit          e_mwe    [2];

    // observed events for the directed timing checks
    int          iack_cyc [2];
    int          dack_cyc [2];
    int          men_cyc  [2];
    int          iack_n   [2];
    int          dack_n   [2];
    int          men_n    [2];
    logic [31:0] men_addr [2];
    logic [31:0] men_wdata[2];
    bit          men_we   [2];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [lat%0d] cyc=%0d got=%h want=%h", nm, lat(k), cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [lat%0d] cyc=%0d got=%b want=%b", nm, lat(k), cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        mb[k]       = 1'b0;
        mlast[k]    = 1'b0;
        e_irdata[k] = '0;
        e_drdata[k] = '0;
        e_maddr[k]  = '0;
        e_mwdata[k] = '0;
        e_mwe[k]    = 1'b0;
    endtask

    task automatic check_cycle();
        for (int k = 0; k < 2; k++) begin
            bit e_men;
            bit e_ia;
            bit e_da;
            e_men = mb[k] && (cyc == mti[k]);
            e_ia  = mb[k] && (cyc == mta[k]) && !mg[k];
            e_da  = mb[k] && (cyc == mta[k]) && mg[k];
            if (mb[k] && (cyc == mta[k]) && !e_mwe[k]) begin
                if (mg[k]) e_drdata[k] = mrd[k];
                else       e_irdata[k] = mrd[k];
            end
            if (chk_on) begin
                chk1("i_ack", k, i_ack[k], e_ia);
                chk1("d_ack", k, d_ack[k], e_da);
                chk1("m_en", k, m_en[k], e_men);
                chk1("busy", k, busy[k], mb[k]);
                chk1("stall_f", k, stall_f[k], i_req[k] & ~e_ia);
                chk1("stall_m", k, stall_m[k], d_req[k] & ~e_da);
                chk("i_rdata", k, i_rdata[k], e_irdata[k]);
                chk("d_rdata", k, d_rdata[k], e_drdata[k]);
                chk("m_addr", k, m_addr[k], e_maddr[k]);
                chk1("m_we", k, m_we[k], e_mwe[k]);
                if (e_men && e_mwe[k]) chk("m_wdata", k, m_wdata[k], e_mwdata[k]);
            end
            if (i_ack[k] === 1'b1) begin iack_cyc[k] = cyc; iack_n[k]++; end
            if (d_ack[k] === 1'b1) begin dack_cyc[k] = cyc; dack_n[k]++; end
            if (m_en[k] === 1'b1) begin
                men_cyc[k] = cyc; men_n[k]++;
                men_addr[k] = m_addr[k]; men_we[k] = m_we[k]; men_wdata[k] = m_wdata[k];
            end
            // advance: an idle arbiter grants at once; the grant occupies MEM_LAT+3 cycles
            if (rst) begin
                model_reset(k);
            end else if (!mb[k]) begin
                if (i_req[k] || d_req[k]) begin
                    bit g;
                    g = (i_req[k] && d_req[k]) ? !mlast[k] : d_req[k];
                    mb[k] = 1'b1; mg[k] = g; mlast[k] = g;
                    mti[k] = cyc + 1;
                    mta[k] = cyc + lat(k) + 2;
                    if (g) begin
                        e_maddr[k] = d_addr[k];
                        e_mwe[k]   = d_we[k];
                        if (d_we[k]) begin
                            e_mwdata[k] = d_wdata[k];
                            mdl_mem[k][d_addr[k][7:2]] = d_wdata[k];
                        end else begin
                            mrd[k] = mdl_mem[k][d_addr[k][7:2]];
                        end
                    end else begin
                        e_maddr[k] = i_addr[k];
                        e_mwe[k]   = 1'b0;
                        mrd[k]     = mdl_mem[k][i_addr[k][7:2]];
                    end
                end
            end else if (cyc == mta[k]) begin
                mb[k] = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check_cycle();
        end
    end

    task automatic drive_step(input bit rnd);
        for (int k = 0; k < 2; k++) begin
            int h;
            int hr;
            logic [5:0] w;
            h = cyc & 15;
            h_en[k][h]   = (m_en[k] === 1'b1);
            h_we[k][h]   = (m_we[k] === 1'b1);
            h_addr[k][h] = m_addr[k];
            if (h_en[k][h] && h_we[k][h]) env_mem[k][m_addr[k][7:2]] = m_wdata[k];
            hr = (cyc - lat(k)) & 15;
            if (h_en[k][hr] && !h_we[k][hr]) m_rdata[k] = env_mem[k][h_addr[k][hr][7:2]];
            else                             m_rdata[k] = $urandom;
            if (i_req[k] && iack_prev[k]) i_req[k] = 1'b0;
            if (d_req[k] && dack_prev[k]) d_req[k] = 1'b0;
            if (rnd) begin
                if (!i_req[k] && $urandom_range(0, 2) == 0) begin
                    w = 6'($urandom);
                    i_req[k]  = 1'b1;
                    i_addr[k] = {24'h0, w, 2'b00};
                end
                if (!d_req[k] && $urandom_range(0, 2) == 0) begin
                    w = 6'($urandom);
                    d_req[k]   = 1'b1;
                    d_we[k]    = 1'($urandom);
                    d_addr[k]  = {24'h0, w, 2'b00};
                    d_wdata[k] = $urandom;
                end
            end
            iack_prev[k] = (i_ack[k] === 1'b1);
            dack_prev[k] = (d_ack[k] === 1'b1);
        end
        if (rnd) rst = ($urandom_range(0, 249) == 0);
    endtask

    task automatic tick(input bit rnd);
        @(posedge clk);
        #1;
        drive_step(rnd);
    endtask

    function automatic bit any_req();
        return i_req[0] || d_req[0] || i_req[1] || d_req[1];
    endfunction

    task automatic wait_drain();
        for (int n = 0; n < 60 && any_req(); n++) tick(1'b0);
        for (int k = 0; k < 2; k++) begin
            chk1("drain_i", k, i_req[k], 1'b0);
            chk1("drain_d", k, d_req[k], 1'b0);
        end
        tick(1'b0);
    endtask

    task automatic run_txn(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                           input logic [31:0] da, input logic [31:0] dwd, output int r);
        tick(1'b0);
        for (int k = 0; k < 2; k++) begin
            i_req[k] = ir; i_addr[k] = ia;
            d_req[k] = dr; d_we[k] = dwe; d_addr[k] = da; d_wdata[k] = dwd;
        end
        r = cyc;
        wait_drain();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
    endtask

    int r;
    int ia0 [2];
    int da0 [2];
    int me0 [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
            d_addr[k] = '0; d_wdata[k] = '0; m_rdata[k] = '0;
            iack_prev[k] = 1'b0; dack_prev[k] = 1'b0;
            iack_n[k] = 0; dack_n[k] = 0; men_n[k] = 0;
            for (int i = 0; i < 64; i++) begin
                env_mem[k][i] = 32'h1000_0000 + i * 32'h0001_0203;
                mdl_mem[k][i] = env_mem[k][i];
            end
            env_mem[k][4]  = 32'h0050_0093;
            mdl_mem[k][4]  = 32'h0050_0093;
            env_mem[k][16] = 32'h1234_5678;
            mdl_mem[k][16] = 32'h1234_5678;
            for (int i = 0; i < 16; i++) begin
                h_en[k][i] = 1'b0; h_we[k][i] = 1'b0; h_addr[k][i] = '0;
            end
        end

        // reset for two cycles, then idle outputs are all zero
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
        chk_on = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk1("rst_i_ack", k, i_ack[k], 1'b0);
            chk1("rst_d_ack", k, d_ack[k], 1'b0);
            chk1("rst_m_en", k, m_en[k], 1'b0);
            chk1("rst_busy", k, busy[k], 1'b0);
            chk1("rst_stall_f", k, stall_f[k], 1'b0);
            chk("rst_m_addr", k, m_addr[k], 32'h0);
            chk("rst_i_rdata", k, i_rdata[k], 32'h0);
        end
        tick(1'b0);

        // single fetch
        for (int k = 0; k < 2; k++) ia0[k] = iack_n[k];
        run_txn(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, r);
        for (int k = 0; k < 2; k++) begin
            chk("fetch_men_cyc", k, men_cyc[k] - r, 1);
            chk("fetch_men_addr", k, men_addr[k], 32'h10);
            chk("fetch_ack_cyc", k, iack_cyc[k] - r, lat(k) + 2);
            chk("fetch_rdata", k, i_rdata[k], 32'h0050_0093);
            chk("fetch_ack_cnt", k, iack_n[k] - ia0[k], 1);
        end

        // both requesting after reset: D first, then I
        do_reset();
        run_txn(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0, r);
        for (int k = 0; k < 2; k++) begin
            chk("both_d_ack_cyc", k, dack_cyc[k] - r, lat(k) + 2);
            chk("both_i_ack_cyc", k, iack_cyc[k] - r, 2 * lat(k) + 5);
            chk("both_d_rdata", k, d_rdata[k], 32'h1234_5678);
        end
        // after a D-only grant, a both-high request must favour I
        run_txn(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, r);
        run_txn(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0, r);
        for (int k = 0; k < 2; k++) begin
            chk("alt_i_ack_cyc", k, iack_cyc[k] - r, lat(k) + 2);
            chk("alt_d_ack_cyc", k, dack_cyc[k] - r, 2 * lat(k) + 5);
        end

        // write leaves d_rdata untouched
        for (int k = 0; k < 2; k++) begin da0[k] = dack_n[k]; me0[k] = men_n[k]; end
        run_txn(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, r);
        for (int k = 0; k < 2; k++) begin
            chk1("wr_m_we", k, men_we[k], 1'b1);
            chk("wr_m_addr", k, men_addr[k], 32'h20);
            chk("wr_m_wdata", k, men_wdata[k], 32'hDEAD_BEEF);
            chk("wr_men_cnt", k, men_n[k] - me0[k], 1);
            chk("wr_ack_cnt", k, dack_n[k] - da0[k], 1);
            chk("wr_ack_cyc", k, dack_cyc[k] - r, lat(k) + 2);
            chk("wr_d_rdata", k, d_rdata[k], 32'h1234_5678);
        end

        // reset while waiting on memory: aborted fetch is re-arbitrated and served once
        for (int k = 0; k < 2; k++) begin ia0[k] = iack_n[k]; me0[k] = men_n[k]; end
        tick(1'b0);
        for (int k = 0; k < 2; k++) begin i_req[k] = 1'b1; i_addr[k] = 32'h10; end
        r = cyc;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        wait_drain();
        for (int k = 0; k < 2; k++) begin
            chk("abort_ack_cyc", k, iack_cyc[k] - r, lat(k) + 5);
            chk("abort_ack_cnt", k, iack_n[k] - ia0[k], 1);
            chk("abort_men_cnt", k, men_n[k] - me0[k], 2);
            chk("abort_rdata", k, i_rdata[k], 32'h0050_0093);
        end

        // random traffic with occasional resets
        repeat (4000) tick(1'b1);
        rst = 1'b0;
        wait_drain();
        tick(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
